// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low row multiplexing, synchronised column
// returns, full-scan debounce and a single-key press FSM.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multiple_keys
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LOCKOUT
    } key_state_t;

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic [CW-1:0] slot_cnt;
    logic [1:0]    row_idx;
    logic          slot_end;
    logic          scan_done;
    logic [15:0]   snapshot;
    logic [15:0]   last;
    logic [15:0]   accepted;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nxt;

    key_state_t state_q, state_d;
    logic [3:0] key_code_d;
    logic       key_valid_d;
    logic       key_held_d;
    logic       multiple_keys_d;
    logic [4:0] key_count;
    logic [3:0] key_index;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    always_comb begin
        slot_end = (slot_cnt == CW'(SCAN_DIV - 1));
        row_out  = ~(4'b0001 << row_idx);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            row_idx   <= '0;
            snapshot  <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= slot_end && (row_idx == 2'd3);
            if (slot_end) begin
                slot_cnt <= '0;
                row_idx  <= row_idx + 2'd1;
                for (int unsigned c = 0; c < 4; c++) begin
                    snapshot[{row_idx, c[1:0]}] <= ~col_sync[c];
                end
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        if (snapshot != last) begin
            stable_nxt = SW'(1);
        end else if (stable_cnt >= SW'(DEBOUNCE_SCANS)) begin
            stable_nxt = SW'(DEBOUNCE_SCANS);
        end else begin
            stable_nxt = stable_cnt + SW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last       <= '0;
            accepted   <= '0;
            stable_cnt <= '0;
        end else if (scan_done) begin
            last       <= snapshot;
            stable_cnt <= stable_nxt;
            if (stable_nxt == SW'(DEBOUNCE_SCANS)) begin
                accepted <= snapshot;
            end
        end
    end

    always_comb begin
        key_count = '0;
        key_index = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (accepted[i]) begin
                key_count = key_count + 5'd1;
                key_index = i[3:0];
            end
        end
    end

    // LOCKOUT is the idle-but-waiting-for-full-release condition after a
    // multi-key accept, so a leftover single key never yields key_valid.
    always_comb begin
        state_d         = state_q;
        key_code_d      = key_code;
        key_valid_d     = 1'b0;
        key_held_d      = key_held;
        multiple_keys_d = multiple_keys;
        unique case (state_q)
            IDLE: begin
                if (key_count == 5'd0) begin
                    multiple_keys_d = 1'b0;
                end else if (key_count == 5'd1) begin
                    key_code_d      = key_index;
                    key_valid_d     = 1'b1;
                    key_held_d      = 1'b1;
                    multiple_keys_d = 1'b0;
                    state_d         = PRESSED;
                end else begin
                    multiple_keys_d = 1'b1;
                    state_d         = LOCKOUT;
                end
            end
            PRESSED: begin
                if (key_count == 5'd0) begin
                    key_held_d      = 1'b0;
                    multiple_keys_d = 1'b0;
                    state_d         = IDLE;
                end else begin
                    multiple_keys_d = (key_count > 5'd1);
                end
            end
            LOCKOUT: begin
                if (key_count == 5'd0) begin
                    multiple_keys_d = 1'b0;
                    state_d         = IDLE;
                end else begin
                    multiple_keys_d = (key_count > 5'd1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            key_code      <= '0;
            key_valid     <= 1'b0;
            key_held      <= 1'b0;
            multiple_keys <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_code      <= key_code_d;
            key_valid     <= key_valid_d;
            key_held      <= key_held_d;
            multiple_keys <= multiple_keys_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad matrix model
// (SCAN_DIV=4, DEBOUNCE_SCANS=2, one full scan = 16 clocks).
module tb_keypad_scanner;

    logic       clock;
    logic       reset;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multiple_keys;

    logic [3:0][3:0] pressed;
    int errors;
    int checks;
    int vcount;
    logic [3:0] vcode;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .col_in       (col_in),
        .row_out      (row_out),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_held     (key_held),
        .multiple_keys(multiple_keys)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        col_in = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (key_valid === 1'b1) begin
            vcount = vcount + 1;
            vcode  = key_code;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input logic v);
        pressed[k[3:2]][k[1:0]] = v;
    endtask

    task automatic wait_pulse(input int base);
        for (int n = 0; n < 200 && vcount == base; n++) @(negedge clock);
    endtask

    task automatic wait_level(input int which, input logic lvl);
        for (int n = 0; n < 200; n++) begin
            if (which == 0 && key_held === lvl) break;
            if (which == 1 && multiple_keys === lvl) break;
            @(negedge clock);
        end
    endtask

    initial begin
        int base;
        logic [3:0] exp_row;
        errors  = 0;
        checks  = 0;
        vcount  = 0;
        vcode   = '0;
        pressed = '0;
        reset   = 1'b1;
        repeat (3) @(posedge clock);

        // 1: reset values and row rotation
        check("reset_row", {12'h0, row_out}, 16'he);
        check("reset_outs", {12'h0, key_code[3:1], key_code[0] | key_valid | key_held | multiple_keys}, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check("row_seq", {12'h0, row_out}, {12'h0, exp_row});
            @(negedge clock);
        end
        repeat (48) @(negedge clock);
        check("idle_no_valid", 16'(vcount), 16'd0);
        check("idle_held", {15'h0, key_held}, 16'h0);

        // 2: clean press of row 2 / col 1
        base = vcount;
        press(4'h9, 1'b1);
        wait_pulse(base);
        check("k9_pulse", 16'(vcount - base), 16'd1);
        check("k9_code", {12'h0, vcode}, 16'h9);
        check("k9_held", {15'h0, key_held}, 16'h1);
        repeat (100) @(negedge clock);
        check("k9_no_repeat", 16'(vcount - base), 16'd1);
        press(4'h9, 1'b0);
        wait_level(0, 1'b0);
        check("k9_release", {15'h0, key_held}, 16'h0);

        // 3: chatter that differs on every scan, then a steady hold
        repeat (32) @(negedge clock);
        base = vcount;
        for (int t = 0; t < 13; t++) begin
            press(4'h3, (t % 2 == 0));
            repeat (16) @(negedge clock);
        end
        check("bounce_reject", 16'(vcount - base), 16'd0);
        press(4'h3, 1'b1);
        wait_pulse(base);
        check("k3_pulse", 16'(vcount - base), 16'd1);
        check("k3_code", {12'h0, vcode}, 16'h3);
        press(4'h3, 1'b0);
        wait_level(0, 1'b0);

        // 4: two keys together lock out until full release
        repeat (32) @(negedge clock);
        base = vcount;
        press(4'h0, 1'b1);
        press(4'hf, 1'b1);
        wait_level(1, 1'b1);
        check("multi_flag", {15'h0, multiple_keys}, 16'h1);
        check("multi_no_valid", 16'(vcount - base), 16'd0);
        press(4'hf, 1'b0);
        repeat (100) @(negedge clock);
        check("lockout_no_valid", 16'(vcount - base), 16'd0);
        check("lockout_mk", {15'h0, multiple_keys}, 16'h0);
        check("lockout_held", {15'h0, key_held}, 16'h0);
        press(4'h0, 1'b0);
        repeat (100) @(negedge clock);
        check("lockout_release", 16'(vcount - base), 16'd0);

        // 5: added key while one is held
        base = vcount;
        press(4'h5, 1'b1);
        wait_pulse(base);
        check("k5_code", {12'h0, vcode}, 16'h5);
        press(4'ha, 1'b1);
        wait_level(1, 1'b1);
        check("k5a_mk", {15'h0, multiple_keys}, 16'h1);
        check("k5a_code", {12'h0, key_code}, 16'h5);
        check("k5a_pulses", 16'(vcount - base), 16'd1);
        press(4'h5, 1'b0);
        press(4'ha, 1'b0);
        wait_level(0, 1'b0);
        check("k5a_release", {14'h0, key_held, multiple_keys}, 16'h0);

        // 6: reset while 7 is held
        repeat (32) @(negedge clock);
        base = vcount;
        press(4'h7, 1'b1);
        wait_pulse(base);
        check("k7_code", {12'h0, vcode}, 16'h7);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_async", {row_out, key_code, 5'h0, key_valid, key_held, multiple_keys}, 16'he000);
        repeat (3) @(posedge clock);
        #1;
        check("rst_hold", {row_out, key_code, 5'h0, key_valid, key_held, multiple_keys}, 16'he000);
        @(negedge clock);
        reset = 1'b0;
        base = vcount;
        wait_pulse(base);
        check("k7_redetect", 16'(vcount - base), 16'd1);
        check("k7_code2", {12'h0, vcode}, 16'h7);
        check("k7_held", {15'h0, key_held}, 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
